// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and constants.
//   axi4_lite_cfg_t : bus configuration (A = address bits, N = data bytes, 4 or 8)
//   csr_mode_t      : per-register access mode of the CSR bank
//   OKAY/SLVERR/DECERR : B/R response codes
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned A;
    int unsigned N;
  } axi4_lite_cfg_t;

  localparam axi4_lite_cfg_t Axi4LiteCfgDefault = '{A: 32'd16, N: 32'd4};

  typedef enum logic [1:0] {CSR_RW, CSR_RO, CSR_W1C, CSR_PULSE} csr_mode_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R), no protection signals.
//   slave  modport : used by the CSR bank
//   master modport : used by an initiator
interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = axi4_lite_pkg::Axi4LiteCfgDefault
);
  logic             awvalid;
  logic             awready;
  logic [C.A-1:0]   awaddr;
  logic             wvalid;
  logic             wready;
  logic [C.N*8-1:0] wdata;
  logic [C.N-1:0]   wstrb;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [C.A-1:0]   araddr;
  logic             rvalid;
  logic             rready;
  logic [C.N*8-1:0] rdata;
  logic [1:0]       rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_csr_cell.sv
// One CSR of the bank; behaviour fixed by Mode.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   we_i          : write commit strobe for this register
//   wdata_i/wstrb_i : write data and byte strobes
//   hw_d_i        : hardware value (RO mode)
//   hw_set_i      : per-bit set pulses (W1C mode)
//   q_o           : current register value
module axi4_lite_csr_cell
  import axi4_lite_pkg::*;
#(
  parameter csr_mode_t          Mode   = CSR_RW,
  parameter int unsigned        Dw     = 32,
  parameter logic [Dw-1:0]      RstVal = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [Dw-1:0]   wdata_i,
  input  logic [Dw/8-1:0] wstrb_i,
  input  logic [Dw-1:0]   hw_d_i,
  input  logic [Dw-1:0]   hw_set_i,
  output logic [Dw-1:0]   q_o
);

  // RO registers hold a sampled copy of hw_d, which is 0 until first sampled.
  localparam logic [Dw-1:0] RstEff = (Mode == CSR_RO) ? '0 : RstVal;

  logic [Dw-1:0] mask;
  logic [Dw-1:0] q_d, q_q;

  always_comb begin
    mask = '0;
    for (int k = 0; k < Dw / 8; k++) mask[8*k +: 8] = {8{wstrb_i[k]}};
  end

  always_comb begin
    q_d = q_q;
    case (Mode)
      CSR_RW:    if (we_i) q_d = (q_q & ~mask) | (wdata_i & mask);
      CSR_RO:    q_d = hw_d_i;
      CSR_W1C: begin
        if (we_i) q_d = q_q & ~(wdata_i & mask);
        // Set is applied after the clear so a coincident hardware set wins.
        q_d = q_d | hw_set_i;
      end
      CSR_PULSE: q_d = we_i ? (wdata_i & mask) : '0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= RstEff;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/axi4_lite_csr_bank.sv
// AXI4-Lite slave register bank of 2**CLOG2_W registers, C.N bytes each.
//   aclk, aresetn : clock, synchronous active-low reset
//   axi4_s        : AXI4-Lite slave port
//   hw_d          : hardware values for RO registers
//   hw_set        : per-bit set pulses for W1C registers
//   reg_q         : current register contents
//   wr_stb        : pulse in the cycle after a register commits a write
//   rd_stb        : pulse on the AR handshake of an in-range read
module axi4_lite_csr_bank
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t                     C       = Axi4LiteCfgDefault,
  parameter int unsigned                        CLOG2_W = 4,
  parameter csr_mode_t [2**CLOG2_W-1:0]         MODE    = '0,
  parameter logic [2**CLOG2_W-1:0][C.N*8-1:0]   RST_V   = '0
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  axi4_lite_if.slave                            axi4_s,
  input  logic [2**CLOG2_W-1:0][C.N*8-1:0]      hw_d,
  input  logic [2**CLOG2_W-1:0][C.N*8-1:0]      hw_set,
  output logic [2**CLOG2_W-1:0][C.N*8-1:0]      reg_q,
  output logic [2**CLOG2_W-1:0]                 wr_stb,
  output logic [2**CLOG2_W-1:0]                 rd_stb
);

  localparam int unsigned W     = 2**CLOG2_W;
  localparam int unsigned Dw    = C.N * 8;
  localparam int unsigned Aw    = C.A;
  localparam int unsigned Off   = $clog2(C.N);
  localparam int unsigned IdxHi = CLOG2_W + Off;

  // Holds the ready outputs low until the first cycle after reset.
  logic ready_q;

  logic            aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [Aw-1:0]   aw_addr_q, aw_addr_d;
  logic [Dw-1:0]   w_data_q, w_data_d;
  logic [C.N-1:0]  w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [Dw-1:0]   rdata_q, rdata_d;
  logic [W-1:0]    wr_stb_q, wr_stb_d;

  logic                aw_hs, w_hs, ar_hs, wr_go, wr_dec, wr_ro, rd_dec;
  logic [Aw-1:0]       wr_addr;
  logic [Dw-1:0]       wr_data;
  logic [C.N-1:0]      wr_strb;
  logic [CLOG2_W-1:0]  wr_idx, rd_idx;
  logic [W-1:0]        wr_sel;

  assign axi4_s.awready = ready_q & ~aw_full_q & ~bvalid_q;
  assign axi4_s.wready  = ready_q & ~w_full_q & ~bvalid_q;
  assign axi4_s.arready = ready_q & ~rvalid_q;
  assign axi4_s.bvalid  = bvalid_q;
  assign axi4_s.bresp   = bresp_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.rdata   = rdata_q;
  assign axi4_s.rresp   = rresp_q;

  assign aw_hs = axi4_s.awvalid & axi4_s.awready;
  assign w_hs  = axi4_s.wvalid & axi4_s.wready;
  assign ar_hs = axi4_s.arvalid & axi4_s.arready;

  // A slot being filled this cycle counts as full, so the write commits at
  // the edge that completes the second handshake.
  assign wr_addr = aw_full_q ? aw_addr_q : axi4_s.awaddr;
  assign wr_data = w_full_q ? w_data_q : axi4_s.wdata;
  assign wr_strb = w_full_q ? w_strb_q : axi4_s.wstrb;
  assign wr_go   = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~bvalid_q;

  assign wr_idx = wr_addr[Off +: CLOG2_W];
  assign wr_dec = |wr_addr[Aw-1:IdxHi];
  assign wr_ro  = (MODE[wr_idx] == CSR_RO);
  assign rd_idx = axi4_s.araddr[Off +: CLOG2_W];
  assign rd_dec = |axi4_s.araddr[Aw-1:IdxHi];

  // Byte-offset address bits take no part in decode.
  logic unused_addr;
  assign unused_addr = ^{wr_addr[Off-1:0], axi4_s.araddr[Off-1:0]};

  always_comb begin
    wr_sel = '0;
    rd_stb = '0;
    if (wr_go && !wr_dec) wr_sel[wr_idx] = 1'b1;
    if (ar_hs && !rd_dec) rd_stb[rd_idx] = 1'b1;
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    wr_stb_d  = wr_ro ? '0 : wr_sel;
    if (wr_go) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_dec ? DECERR : (wr_ro ? SLVERR : OKAY);
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = axi4_s.awaddr;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = axi4_s.wdata;
        w_strb_d = axi4_s.wstrb;
      end
      if (axi4_s.bready) bvalid_d = 1'b0;
    end
    // Sampled before this edge's write lands, so a colliding read sees old data.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_dec ? DECERR : OKAY;
      rdata_d  = rd_dec ? '0 : reg_q[rd_idx];
    end else if (axi4_s.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ready_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      wr_stb_q  <= '0;
    end else begin
      ready_q   <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  assign wr_stb = wr_stb_q;

  for (genvar i = 0; i < W; i++) begin : g_cell
    axi4_lite_csr_cell #(
      .Mode   (MODE[i]),
      .Dw     (Dw),
      .RstVal (RST_V[i])
    ) u_cell (
      .clk_i    (aclk),
      .rst_ni   (aresetn),
      .we_i     (wr_sel[i]),
      .wdata_i  (wr_data),
      .wstrb_i  (wr_strb),
      .hw_d_i   (hw_d[i]),
      .hw_set_i (hw_set[i]),
      .q_o      (reg_q[i])
    );
  end

endmodule
